// File: rtl/sdram_state_ctrl_if.sv
// sdram_state_ctrl_if -- request/acknowledge bundle between an SDRAM client
// (master) and the SDRAM command-state controller (slave).
//
// Handshake: sdram_wr_req / sdram_rd_req are level requests. The client raises
// one with a stable burst length and holds it until it sees the matching
// sdram_wr_ack / sdram_rd_ack data-phase strobe. The controller samples the
// request only while idle. The ack strobes mark the data beats. A request
// dropped after the first ack never shortens the transaction already started.
interface sdram_state_ctrl_if;
  logic       sdram_wr_req;
  logic       sdram_rd_req;
  logic [9:0] sdram_wr_burst;
  logic [9:0] sdram_rd_burst;
  logic       sdram_wr_ack;
  logic       sdram_rd_ack;
  logic       sdram_rd_wr;
  logic       sdram_init_done;

  modport master (
    output sdram_wr_req,
    output sdram_rd_req,
    output sdram_wr_burst,
    output sdram_rd_burst,
    input  sdram_wr_ack,
    input  sdram_rd_ack,
    input  sdram_rd_wr,
    input  sdram_init_done
  );

  modport slave (
    input  sdram_wr_req,
    input  sdram_rd_req,
    input  sdram_wr_burst,
    input  sdram_rd_burst,
    output sdram_wr_ack,
    output sdram_rd_ack,
    output sdram_rd_wr,
    output sdram_init_done
  );
endinterface

// File: rtl/sdram_state_ctrl.sv
// sdram_state_ctrl -- SDRAM power-up initialisation and access/refresh
// sequencing. It produces the init and work state codes and the cycles-in-state
// count (cnt_clk) that a downstream encoder turns into SDRAM commands.
//
// Optional macro SDRAM_FAST_INIT_EN: when defined, the power-up NOP wait is
// 20 cycles and the refresh period is 100 cycles, whatever the parameters say.
// When undefined, INIT_WAIT and REF_INTERVAL apply.
module sdram_state_ctrl #(
  parameter int INIT_WAIT    = 20000,
  parameter int REF_INTERVAL = 780,
  parameter int TRP_CLK      = 3,
  parameter int TRC_CLK      = 7,
  parameter int TRSC_CLK     = 3,
  parameter int TRCD_CLK     = 3,
  parameter int CAS_LAT      = 3,
  parameter int TWR_CLK      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sdram_state_ctrl_if.slave        bus,
  output logic [4:0]               init_state,
  output logic [3:0]               work_state,
  output logic [9:0]               cnt_clk
);

`ifdef SDRAM_FAST_INIT_EN
  localparam int NOP_WAIT   = 20;
  localparam int REF_PERIOD = 100;
`else
  localparam int NOP_WAIT   = INIT_WAIT;
  localparam int REF_PERIOD = REF_INTERVAL;
`endif

  // The NOP wait can exceed the 10-bit cnt_clk range, so it has its own timer.
  localparam int NOP_W = (NOP_WAIT > 1) ? $clog2(NOP_WAIT) : 1;
  localparam int REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  localparam logic [NOP_W-1:0] NOP_LAST  = NOP_W'(NOP_WAIT - 1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REF_PERIOD - 1);
  localparam logic [9:0]       TRP_LAST  = 10'(TRP_CLK - 1);
  localparam logic [9:0]       TRC_LAST  = 10'(TRC_CLK - 1);
  localparam logic [9:0]       TRSC_LAST = 10'(TRSC_CLK - 1);
  localparam logic [9:0]       TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0]       CL_LAST   = 10'(CAS_LAT - 1);
  localparam logic [9:0]       TWR_LAST  = 10'(TWR_CLK - 1);

  typedef enum logic [4:0] {
    I_NOP  = 5'd0,
    I_PRE  = 5'd1,
    I_TRP  = 5'd2,
    I_AR   = 5'd3,
    I_TRF  = 5'd4,
    I_MRS  = 5'd5,
    I_TRSC = 5'd6,
    I_DONE = 5'd7
  } init_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_t;

  init_t             init_q;
  init_t             init_next;
  work_t             work_q;
  work_t             work_next;
  logic [9:0]        cnt_q;
  logic [NOP_W-1:0]  nop_cnt;
  logic [2:0]        ar_cnt;
  logic [REF_W-1:0]  ref_cnt;
  logic              ref_pending;
  logic              ref_expire;
  logic              ar_entry;
  logic              access_start;
  logic              rd_wr_q;
  logic [9:0]        wr_len;
  logic [9:0]        rd_len;
  logic [9:0]        wd_last;
  logic [9:0]        rd_last;
  logic              wr_ack_q;
  logic              rd_ack_q;
  logic              init_done_q;

  // A zero burst length is a one-word burst.
  function automatic logic [9:0] eff_len(input logic [9:0] b);
    return (b == 10'd0) ? 10'd1 : b;
  endfunction

  assign init_state = init_q;
  assign work_state = work_q;
  assign cnt_clk    = cnt_q;

  assign bus.sdram_wr_ack    = wr_ack_q;
  assign bus.sdram_rd_ack    = rd_ack_q;
  assign bus.sdram_rd_wr     = rd_wr_q;
  assign bus.sdram_init_done = init_done_q;

  // W_WD holds the beats after the one in W_WRITE; W_RD holds every read beat.
  assign wd_last = wr_len - 10'd2;
  assign rd_last = rd_len - 10'd1;

  // The refresh timer only runs once initialisation has completed.
  assign ref_expire   = (init_q == I_DONE) && (ref_cnt == REF_LAST);
  assign ar_entry     = (work_q == W_IDLE) && (work_next == W_AR);
  assign access_start = (work_q == W_IDLE) && (work_next == W_ACTIVE);

  // Next-state decode for the init and work sequencers.
  always_comb begin
    init_next = init_q;
    work_next = work_q;

    case (init_q)
      I_NOP:   if (nop_cnt == NOP_LAST) init_next = I_PRE;
      I_PRE:   init_next = I_TRP;
      I_TRP:   if (cnt_q == TRP_LAST) init_next = I_AR;
      I_AR:    init_next = I_TRF;
      // Eight auto-refresh rounds; ar_cnt counts the rounds already finished.
      I_TRF:   if (cnt_q == TRC_LAST) init_next = (ar_cnt == 3'd7) ? I_MRS : I_AR;
      I_MRS:   init_next = I_TRSC;
      I_TRSC:  if (cnt_q == TRSC_LAST) init_next = I_DONE;
      I_DONE:  init_next = I_DONE;
      default: init_next = I_NOP;
    endcase

    case (work_q)
      // Refresh beats write, write beats read. Nothing starts before init ends.
      W_IDLE: begin
        if (init_q == I_DONE) begin
          if (ref_pending)
            work_next = W_AR;
          else if (bus.sdram_wr_req || bus.sdram_rd_req)
            work_next = W_ACTIVE;
        end
      end
      W_AR:     work_next = W_TRFC;
      W_TRFC:   if (cnt_q == TRC_LAST) work_next = W_IDLE;
      W_ACTIVE: work_next = W_TRCD;
      W_TRCD:   if (cnt_q == TRCD_LAST) work_next = rd_wr_q ? W_READ : W_WRITE;
      W_WRITE:  work_next = (wr_len == 10'd1) ? W_TWR : W_WD;
      W_WD:     if (cnt_q == wd_last) work_next = W_TWR;
      W_TWR:    if (cnt_q == TWR_LAST) work_next = W_PRE;
      W_READ:   work_next = W_CL;
      W_CL:     if (cnt_q == CL_LAST) work_next = W_RD;
      W_RD:     if (cnt_q == rd_last) work_next = W_PRE;
      W_PRE:    work_next = W_TRP;
      W_TRP:    if (cnt_q == TRP_LAST) work_next = W_IDLE;
      default:  work_next = W_IDLE;
    endcase
  end

  // State registers, timers, refresh bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_q      <= I_NOP;
      work_q      <= W_IDLE;
      cnt_q       <= 10'd0;
      nop_cnt     <= '0;
      ar_cnt      <= 3'd0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      rd_wr_q     <= 1'b1;
      wr_len      <= 10'd1;
      rd_len      <= 10'd1;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      init_q <= init_next;
      work_q <= work_next;

      // cnt_clk restarts on any state change and otherwise saturates at 1023.
      if ((init_next != init_q) || (work_next != work_q))
        cnt_q <= 10'd0;
      else if (cnt_q != 10'h3ff)
        cnt_q <= cnt_q + 10'd1;

      if ((init_q == I_NOP) && (init_next == I_NOP))
        nop_cnt <= nop_cnt + NOP_W'(1);
      else
        nop_cnt <= '0;

      if ((init_q == I_TRF) && (init_next == I_AR))
        ar_cnt <= ar_cnt + 3'd1;

      if (init_q == I_DONE) begin
        if (ref_expire)
          ref_cnt <= '0;
        else
          ref_cnt <= ref_cnt + REF_W'(1);
      end

      // Expiries while already pending collapse into one; a fresh expiry on
      // the W_AR entry edge keeps the request alive.
      ref_pending <= ref_expire || (ref_pending && !ar_entry);

      // Direction and both burst lengths are frozen for the whole access.
      if (access_start) begin
        rd_wr_q <= !bus.sdram_wr_req;
        wr_len  <= eff_len(bus.sdram_wr_burst);
        rd_len  <= eff_len(bus.sdram_rd_burst);
      end

      wr_ack_q    <= (work_next == W_WRITE) || (work_next == W_WD);
      rd_ack_q    <= (work_next == W_RD);
      init_done_q <= (init_next == I_DONE);
    end
  end

endmodule

// File: tb/tb_sdram_state_ctrl.sv
// tb_sdram_state_ctrl -- self-checking bench for sdram_state_ctrl.
// Drivers push the expected per-cycle trace (init state, work state, cnt_clk,
// acks, direction, init_done) into exp_q. A negedge monitor pops and compares
// every cycle that is not "init done and idle".
module tb_sdram_state_ctrl;

  localparam int T_NOP  = 20;
  localparam int T_TRP  = 3;
  localparam int T_TRC  = 7;
  localparam int T_TRSC = 3;
  localparam int T_TRCD = 3;
  localparam int T_CL   = 3;
  localparam int T_TWR  = 2;

  localparam int WS_IDLE = 0, WS_ACTIVE = 1, WS_TRCD = 2, WS_READ = 3, WS_CL = 4,
                 WS_RD = 5, WS_WRITE = 6, WS_WD = 7, WS_TWR = 8, WS_PRE = 9,
                 WS_TRP = 10, WS_AR = 11, WS_TRFC = 12;

  logic       clk;
  logic       rst_n;
  logic [4:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;

  sdram_state_ctrl_if bus ();

  sdram_state_ctrl #(
    .INIT_WAIT    (20),
    .REF_INTERVAL (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .init_state (init_state),
    .work_state (work_state),
    .cnt_clk    (cnt_clk)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [22:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  int          t_done = 0;
  logic [22:0] cur;
  logic [22:0] exp_item;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] mk(input int ist, input int wst, input int cnt,
                                     input logic wa, input logic ra, input logic rw,
                                     input logic dn);
    return {5'(ist), 4'(wst), 10'(cnt), wa, ra, rw, dn};
  endfunction

  task automatic push_run(input int wst, input int n, input logic wa, input logic ra,
                          input logic rw);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(7, wst, i, wa, ra, rw, 1'b1));
  endtask

  // The cycle between the last reset edge and the first free edge is not
  // monitored, so the NOP run starts at cnt_clk = 1.
  task automatic push_init();
    for (int i = 1; i < T_NOP; i++) exp_q.push_back(mk(0, 0, i, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < T_TRP; i++) exp_q.push_back(mk(2, 0, i, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(mk(3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < T_TRC; i++) exp_q.push_back(mk(4, 0, i, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    exp_q.push_back(mk(5, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < T_TRSC; i++) exp_q.push_back(mk(6, 0, i, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic push_write(input int b);
    int eb;
    eb = (b == 0) ? 1 : b;
    push_run(WS_ACTIVE, 1, 1'b0, 1'b0, 1'b0);
    push_run(WS_TRCD, T_TRCD, 1'b0, 1'b0, 1'b0);
    push_run(WS_WRITE, 1, 1'b1, 1'b0, 1'b0);
    if (eb > 1) push_run(WS_WD, eb - 1, 1'b1, 1'b0, 1'b0);
    push_run(WS_TWR, T_TWR, 1'b0, 1'b0, 1'b0);
    push_run(WS_PRE, 1, 1'b0, 1'b0, 1'b0);
    push_run(WS_TRP, T_TRP, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_read(input int b);
    int eb;
    eb = (b == 0) ? 1 : b;
    push_run(WS_ACTIVE, 1, 1'b0, 1'b0, 1'b1);
    push_run(WS_TRCD, T_TRCD, 1'b0, 1'b0, 1'b1);
    push_run(WS_READ, 1, 1'b0, 1'b0, 1'b1);
    push_run(WS_CL, T_CL, 1'b0, 1'b0, 1'b1);
    push_run(WS_RD, eb, 1'b0, 1'b1, 1'b1);
    push_run(WS_PRE, 1, 1'b0, 1'b0, 1'b1);
    push_run(WS_TRP, T_TRP, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_ref(input logic rw);
    push_run(WS_AR, 1, 1'b0, 1'b0, rw);
    push_run(WS_TRFC, T_TRC, 1'b0, 1'b0, rw);
  endtask

  // Monitor: one comparison per active cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && (init_state != 5'd7 || work_state != 4'd0)) begin
      cur = {init_state, work_state, cnt_clk, bus.sdram_wr_ack, bus.sdram_rd_ack,
             bus.sdram_rd_wr, bus.sdram_init_done};
      if (exp_q.size() == 0) begin
        check("unexpected_activity", exp_q.size(), 1);
      end else begin
        exp_item = exp_q.pop_front();
        check("trace", cur, exp_item);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks return on a falling edge; input changes happen 1 time unit later.
  task automatic check_reset_values();
    check("rst_init_state", init_state, 0);
    check("rst_work_state", work_state, 0);
    check("rst_cnt_clk", cnt_clk, 0);
    check("rst_rd_wr", bus.sdram_rd_wr, 1);
    check("rst_wr_ack", bus.sdram_wr_ack, 0);
    check("rst_rd_ack", bus.sdram_rd_ack, 0);
    check("rst_init_done", bus.sdram_init_done, 0);
  endtask

  task automatic release_reset();
    int n;
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    push_init();
    mon_en = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.sdram_init_done) break;
    end
    check("init_done_latency", n, 92);
    t_done = cyc;
  endtask

  task automatic wait_wr_ack();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.sdram_wr_ack) break;
    end
    check("wr_ack_seen", bus.sdram_wr_ack, 1);
  endtask

  task automatic wait_rd_ack();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.sdram_rd_ack) break;
    end
    check("rd_ack_seen", bus.sdram_rd_ack, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (work_state == 4'd0) break;
    end
    check("idle_seen", work_state, 0);
  endtask

  task automatic do_write(input int b);
    #1;
    push_write(b);
    bus.sdram_wr_burst = 10'(b);
    bus.sdram_wr_req   = 1'b1;
    wait_wr_ack();
    #1 bus.sdram_wr_req = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input int b);
    #1;
    push_read(b);
    bus.sdram_rd_burst = 10'(b);
    bus.sdram_rd_req   = 1'b1;
    wait_rd_ack();
    #1 bus.sdram_rd_req = 1'b0;
    wait_idle();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n              = 1'b0;
    bus.sdram_wr_req   = 1'b0;
    bus.sdram_rd_req   = 1'b0;
    bus.sdram_wr_burst = 10'd0;
    bus.sdram_rd_burst = 10'd0;
    repeat (4) @(negedge clk);
    check_reset_values();

    // A write request held through init must not be acknowledged until done.
    bus.sdram_wr_burst = 10'd8;
    bus.sdram_wr_req   = 1'b1;
    release_reset();
    push_write(8);
    wait_wr_ack();
    #1 bus.sdram_wr_req = 1'b0;
    wait_idle();

    do_read(1);
    do_write(0);
    do_read(4);

    // Long read spanning the first refresh expiry; write and read queued behind.
    wait_until(t_done + 88);
    #1;
    push_read(16);
    bus.sdram_rd_burst = 10'd16;
    bus.sdram_rd_req   = 1'b1;
    wait_rd_ack();
    #1;
    push_ref(1'b1);
    push_write(2);
    push_read(3);
    bus.sdram_wr_burst = 10'd2;
    bus.sdram_rd_burst = 10'd3;
    bus.sdram_wr_req   = 1'b1;
    bus.sdram_rd_req   = 1'b1;
    wait_wr_ack();
    #1 bus.sdram_wr_req = 1'b0;
    wait_rd_ack();
    #1 bus.sdram_rd_req = 1'b0;
    wait_idle();

    // One-cycle reset in the middle of a read data phase.
    #1;
    push_read(8);
    bus.sdram_rd_burst = 10'd8;
    bus.sdram_rd_req   = 1'b1;
    wait_rd_ack();
    #1 bus.sdram_rd_req = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check_reset_values();
    bus.sdram_rd_burst = 10'd1;
    bus.sdram_rd_req   = 1'b1;
    release_reset();
    push_read(1);
    wait_rd_ack();
    #1 bus.sdram_rd_req = 1'b0;
    wait_idle();

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_state_ctrl.md
SDRAM_STATE_CTRL -- requirements
Module: sdram_state_ctrl

Interface
REQ-001 Parameter INIT_WAIT, 20000, power-up wait cycles (200 us at 100 MHz).
REQ-002 Parameter REF_INTERVAL, 780, auto-refresh period in cycles (7.8 us).
REQ-003 Parameters TRP_CLK 3, TRC_CLK 7, TRSC_CLK 3, TRCD_CLK 3, CAS_LAT 3, TWR_CLK 2: command-gap cycle counts.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous and active-low.
REQ-006 sdram_wr_req  in  1  write burst request, level, held until sdram_wr_ack seen.
REQ-007 sdram_rd_req  in  1  read burst request, level, held until sdram_rd_ack seen.
REQ-008 sdram_wr_burst / sdram_rd_burst  in  10 each  burst length in words; 0 treated as 1.
REQ-009 init_state  out  5  I_NOP=0 I_PRE=1 I_TRP=2 I_AR=3 I_TRF=4 I_MRS=5 I_TRSC=6 I_DONE=7.
REQ-010 work_state  out  4  W_IDLE=0 W_ACTIVE=1 W_TRCD=2 W_READ=3 W_CL=4 W_RD=5 W_WRITE=6 W_WD=7 W_TWR=8 W_PRE=9 W_TRP=10 W_AR=11 W_TRFC=12.
REQ-011 cnt_clk  out  10  cycles spent in current state, consumed by the downstream command encoder.
REQ-012 sdram_rd_wr  out  1  transaction direction, 0 write, 1 read.
REQ-013 sdram_wr_ack / sdram_rd_ack  out  1 each  data-phase strobes.
REQ-014 sdram_init_done  out  1  high from first cycle of I_DONE onward.

Function
REQ-015 cnt_clk SHALL clear to 0 on any init_state or work_state change, else increment, saturating at 1023.
REQ-016 Init: I_NOP for INIT_WAIT cycles -> I_PRE 1 cycle -> I_TRP TRP_CLK cycles -> I_AR 1 -> I_TRF TRC_CLK; I_AR/I_TRF pair SHALL repeat 8 times total -> I_MRS 1 -> I_TRSC TRSC_CLK -> I_DONE (terminal).
REQ-017 work_state SHALL stay W_IDLE while init_state != I_DONE; requests during init ignored (no ack).
REQ-018 Refresh counter SHALL start at I_DONE, set ref_pending every REF_INTERVAL cycles; ref_pending clears on entry to W_AR; a further expiry while pending stays a single pending.
REQ-019 In W_IDLE priority SHALL be ref_pending > sdram_wr_req > sdram_rd_req, evaluated each cycle.
REQ-020 Refresh path: W_AR 1 cycle -> W_TRFC TRC_CLK cycles -> W_IDLE.
REQ-021 Access path: W_ACTIVE 1 -> W_TRCD TRCD_CLK -> W_WRITE or W_READ.
REQ-022 Write: W_WRITE 1 -> W_WD (burst-1) cycles (skipped if burst=1) -> W_TWR TWR_CLK -> W_PRE 1 -> W_TRP TRP_CLK -> W_IDLE.
REQ-023 Read: W_READ 1 -> W_CL CAS_LAT cycles -> W_RD burst cycles -> W_PRE 1 -> W_TRP TRP_CLK -> W_IDLE.
REQ-024 sdram_wr_ack SHALL be high in W_WRITE and all of W_WD (exactly wr_burst cycles); sdram_rd_ack high for all of W_RD (exactly rd_burst cycles).
REQ-025 sdram_rd_wr SHALL load on leaving W_IDLE to an access and hold until next access; burst lengths sampled at same edge and held.
REQ-026 A request dropped mid-transaction SHALL NOT abort it; refresh never preempts an access.

Reset
REQ-027 With rst_n low at a clk edge: init_state=I_NOP, work_state=W_IDLE, cnt_clk=0, sdram_rd_wr=1, acks=0, sdram_init_done=0, ref_pending=0, refresh counter=0; full init reruns even if asserted mid-burst.

Configuration
REQ-028 Macro SDRAM_FAST_INIT_EN defined: I_NOP wait SHALL be 20 cycles and REF_INTERVAL forced to 100; undefined: parameter values apply.

Verification
REQ-029 Reset, run with SDRAM_FAST_INIT_EN -> init_state sequence 0,1,2,(3,4)x8,5,6,7; sdram_init_done rises 20+1+3+8x8+1+3 = 92 cycles after reset release.
REQ-030 Write req, wr_burst=8 -> W_ACTIVE, 3xW_TRCD, W_WRITE, 7xW_WD, 2xW_TWR, W_PRE, 3xW_TRP; wr_ack high 8 cycles; sdram_rd_wr=0.
REQ-031 Read req, rd_burst=1 -> 3xW_CL then 1xW_RD; rd_ack high exactly 1 cycle; sdram_rd_wr=1.
REQ-032 wr_req, rd_req and ref_pending all asserted in W_IDLE -> W_AR first, then write, then read.
REQ-033 Burst=0 request -> treated as 1: one ack cycle, W_WD skipped.
REQ-034 rst_n low for 1 cycle during W_RD -> all outputs at reset values next cycle, rd_ack 0, init restarts.
